ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_keyboard_if.sv | 19 +
 rtl/kbd_fifo.sv | 61 ++++++
 rtl/ps2_keyboard.sv | 165 ++++++++++++++++
 tb/tb_ps2_keyboard.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard receiver.
//   FIFO_DEPTH_DEF / TIMEOUT_CYC_DEF : default parameter values
//   FRAME_BITS                       : start + 8 data + parity + stop
//   rx_state_e                       : receiver FSM state encoding
//   frame_ok()                       : odd-parity and stop-bit check
package ps2_pkg;

  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 20000;
  localparam int FRAME_BITS      = 11;

  // Bit counter value at which the stop bit is sampled.
  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  // dp = {parity, d7..d0}. A frame is good when the nine bits hold an odd
  // number of ones and the stop bit is high.
  function automatic logic frame_ok(input logic [8:0] dp, input logic stop);
    return (^dp) & stop;
  endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: IO-bus side of the keyboard controller.
//   rdn       : active-low read strobe; a byte is consumed on its rising edge
//   data      : byte at the FIFO head, 8'h00 while nothing is buffered
//   ready     : at least one byte is buffered
//   overflow  : sticky, a good byte was lost because the buffer was full
//   frame_err : one-cycle pulse per rejected frame
// Handshake: data is valid whenever ready=1 and holds steady while rdn is
// low; the byte is retired on the low-to-high transition of rdn, and a
// strobe seen with ready=0 has no effect.
interface ps2_keyboard_if;
  logic       rdn;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  modport master (output rdn, input data, ready, overflow, frame_err);
  modport slave  (input rdn, output data, ready, overflow, frame_err);
endinterface

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous FIFO for received scan codes.
//   clk, clrn : clock, synchronous active-low reset
//   push/din  : write request and data (ignored when full unless popping)
//   pop/dout  : read request and head-of-queue data (ignored when empty)
//   empty/full: occupancy flags
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clrn && wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH by overflow.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with a scan-code FIFO.
//   clk, clrn          : system clock, synchronous active-low reset
//   ps2_clk, ps2_data  : raw PS/2 lines, asynchronous to clk
//   bus (slave)        : rdn in; data, ready, overflow, frame_err out
//   rx_state           : receiver FSM state, for observation
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_keyboard_if.slave   bus,
  output rx_state_e       rx_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // ---------------- input synchronizers ----------------
  // Bit 0 is the newest stage, bit 2 the oldest.
  logic [2:0] clk_sync;
  logic [2:0] dat_sync;
  logic       fall;
  logic       din;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  // Data is taken from the same stage as the newer half of the edge detector
  // so both lines see identical synchronizer delay.
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign din  = dat_sync[1];

  // ---------------- receiver FSM ----------------
  rx_state_e     state;
  rx_state_e     state_nxt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;
  logic [TW-1:0] idle_cnt;
  logic          frame_end;
  logic          frame_good;
  logic          timeout;
  logic          push;
  logic          reject;
  logic          frame_err_q;

  always_ff @(posedge clk) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fall && !din)         state_nxt = ST_RECV;
      ST_RECV: if (frame_end || timeout) state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_end  = 1'b0;
    timeout    = 1'b0;
    frame_good = 1'b0;
    push       = 1'b0;
    reject     = 1'b0;
    if (state == ST_RECV) begin
      frame_end  = fall && (bit_cnt == STOP_IDX);
      // idle_cnt counts cycles since the last edge; this is the last allowed one.
      timeout    = !fall && (idle_cnt == TW'(TIMEOUT_CYC - 1));
      frame_good = frame_end && frame_ok(shift, din);
      push       = frame_good;
      reject     = (frame_end && !frame_good) || timeout;
    end
  end

  // Shift register fills from the top, so after nine edges shift[7:0] holds
  // d7..d0 in natural order and shift[8] holds the parity bit.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      bit_cnt     <= '0;
      shift       <= '0;
      idle_cnt    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= reject;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (fall && !din) begin
            bit_cnt <= 4'd1;
            shift   <= '0;
          end
        end
        ST_RECV: begin
          if (frame_end || timeout) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end else if (fall) begin
            shift    <= {din, shift[8:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // ---------------- bus read side ----------------
  logic       rdn_d;
  logic       pop;
  logic       empty;
  logic       full;
  logic       overflow_q;
  logic [7:0] fifo_dout;

  always_ff @(posedge clk) begin
    if (!clrn) rdn_d <= 1'b1;
    else       rdn_d <= bus.rdn;
  end

  // Retire the head on the rising edge of rdn, so data is steady while low.
  assign pop = bus.rdn & ~rdn_d & ~empty;

  kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .din   (shift[7:0]),
    .dout  (fifo_dout),
    .empty (empty),
    .full  (full)
  );

  // A pop in the same cycle makes room, so a byte is only lost when not popping.
  always_ff @(posedge clk) begin
    if (!clrn)             overflow_q <= 1'b0;
    else if (pop)          overflow_q <= 1'b0;
    else if (push && full) overflow_q <= 1'b1;
  end

  assign bus.data      = empty ? 8'h00 : fifo_dout;
  assign bus.ready     = ~empty;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
  assign rx_state      = state;

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;

  // ---------------- clock / reset ----------------
  logic      clk = 1'b0;
  logic      clrn = 1'b0;
  logic      ps2_clk = 1'b1;
  logic      ps2_data = 1'b1;
  rx_state_e rx_state;

  always #5 clk = ~clk;

  ps2_keyboard_if bus ();

  ps2_keyboard #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus),
    .rx_state (rx_state)
  );

  // ---------------- scoreboard state ----------------
  int         vec_cnt = 0;
  int         miscmp  = 0;
  int         hp      = 20;      // PS/2 half period in clk cycles
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  int         err_exp = 0;
  int         err_seen = 0;

  always @(negedge clk) if (bus.frame_err) err_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Frame layout on the wire, LSB first: start, d0..d7, parity, stop.
  function automatic logic [10:0] build(input logic [7:0] b, input logic par_bad,
                                        input logic stop);
    int   ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0) ^ par_bad;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic model_frame(input logic [10:0] v);
    int ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(v[i]);
    if (v[0] == 1'b0 && v[10] == 1'b1 && (ones % 2) == 1) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(v[8:1]);
      else                      exp_ovf = 1'b1;
    end else begin
      err_exp++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bits(input logic [10:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = v[i];
      tick(hp);
      ps2_clk = 1'b0;
      tick(hp);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop);
    logic [10:0] v;
    v = build(b, par_bad, stop);
    send_bits(v, 11);
    tick(hp);
    ps2_data = 1'b1;
    model_frame(v);
    check("frame_err_count", err_seen, err_exp);
    check("ready_after_frame", bus.ready, exp_q.size() > 0);
    check("overflow_after_frame", bus.overflow, exp_ovf);
  endtask

  task automatic read_byte();
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check("ready_before_read", bus.ready, exp_q.size() > 0);
    check("data_before_read", bus.data, e);
    bus.rdn = 1'b0;
    tick(2);
    check("data_while_rdn_low", bus.data, e);
    bus.rdn = 1'b1;
    tick(1);
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_ovf = 1'b0;
    end
    check("ready_after_read", bus.ready, exp_q.size() > 0);
    check("overflow_after_read", bus.overflow, exp_ovf);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick(2);
    clrn = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] v;
    bus.rdn = 1'b1;
    tick(3);
    check("reset_ready", bus.ready, 0);
    check("reset_data", bus.data, 0);
    check("reset_overflow", bus.overflow, 0);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_state", 32'(rx_state), 32'(ST_IDLE));
    clrn = 1'b1;
    tick(2);

    // 0x1C: ready rises exactly one clk after the stop bit is sampled
    v = build(8'h1C, 1'b0, 1'b1);
    send_bits(v, 10);
    ps2_data = v[10];
    tick(hp);
    ps2_clk = 1'b0;
    tick(2);
    check("latency_not_yet", bus.ready, 0);
    tick(1);
    check("latency_ready", bus.ready, 1);
    check("latency_data", bus.data, 8'h1C);
    tick(hp);
    ps2_clk = 1'b1;
    tick(hp);
    model_frame(v);
    read_byte();

    // ordering
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    read_byte();
    read_byte();

    // parity error
    send_frame(8'h1C, 1'b1, 1'b1);

    // overflow: nine frames into an eight-deep buffer
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) read_byte();

    // timeout on a partial frame, then a normal frame
    send_bits(build(8'hA5, 1'b0, 1'b1), 5);
    ps2_data = 1'b1;
    tick(TMO + 1);
    err_exp++;
    send_frame(8'h29, 1'b0, 1'b1);
    read_byte();
    read_byte();

    // reset in the middle of a frame
    send_frame(8'h77, 1'b0, 1'b1);
    send_bits(build(8'h33, 1'b0, 1'b1), 5);
    ps2_data = 1'b1;
    do_reset();
    check("midframe_reset_ready", bus.ready, 0);
    check("midframe_reset_overflow", bus.overflow, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    read_byte();

    // randomized traffic
    repeat (16) begin
      int k;
      hp = $urandom_range(8, 25);
      k  = $urandom_range(0, 5);
      send_frame(8'($urandom_range(0, 255)), k == 4, k != 5);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) read_byte();
      end
    end
    while (exp_q.size() > 0) read_byte();
    read_byte();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
